// File: rtl/f32m_pkg.sv
// Shared types and constants for the GF(3^2M) accumulator slice.
// Operands pack 2M trits, two bits per trit (00=0, 01=1, 10=2).
package f32m_pkg;

  localparam int M      = 4;
  localparam int F32M_W = 4 * M;

  localparam logic [F32M_W-1:0] F32M_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } acc_state_t;

  function automatic logic [1:0] trit_add(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [2:0] t;
    t = {1'b0, x} + {1'b0, y};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction

endpackage

// File: rtl/f32m_add.sv
// Trit-wise mod-3 addition of two packed GF(3^2M) elements.
// Purely combinational.
module f32m_add
  import f32m_pkg::*;
(
  input  logic [F32M_W-1:0] a,
  input  logic [F32M_W-1:0] b,
  output logic [F32M_W-1:0] s
);

  always_comb begin
    s = F32M_ZERO;
    for (int i = 0; i < 2 * M; i++) begin
      s[2*i +: 2] = trit_add(a[2*i +: 2], b[2*i +: 2]);
    end
  end

endmodule

// File: rtl/f32m_neg.sv
// Trit-wise negation: swapping the two code bits maps 1<->2, keeps 0.
// Purely combinational.
module f32m_neg
  import f32m_pkg::*;
(
  input  logic [F32M_W-1:0] a,
  output logic [F32M_W-1:0] y
);

  always_comb begin
    y = F32M_ZERO;
    for (int i = 0; i < 2 * M; i++) begin
      y[2*i]     = a[2*i + 1];
      y[2*i + 1] = a[2*i];
    end
  end

endmodule

// File: rtl/f32m_acc_seq.sv
// Sequential GF(3^2M) accumulator: sums n_ops streamed operands.
// Define F32M_ACC_NEG_EN to add in_neg (per-operand subtraction).
module f32m_acc_seq
  import f32m_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_ops,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [F32M_W-1:0] in_data,
`ifdef F32M_ACC_NEG_EN
  input  logic              in_neg,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [F32M_W-1:0] out_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  acc_state_t        state_q;
  acc_state_t        state_d;
  logic [F32M_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [F32M_W-1:0] operand;
  logic [F32M_W-1:0] sum;
  logic              acc_clr;
  logic              acc_ld;
  logic              cnt_ld;

`ifdef F32M_ACC_NEG_EN
  logic [F32M_W-1:0] neg_data;

  f32m_neg u_neg (
    .a (in_data),
    .y (neg_data)
  );

  assign operand = in_neg ? neg_data : in_data;
`else
  assign operand = in_data;
`endif

  f32m_add u_add (
    .a (acc_q),
    .b (operand),
    .s (sum)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    acc_ld    = 1'b0;
    cnt_ld    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_clr = 1'b1;
          if (n_ops != '0) begin
            cnt_ld  = 1'b1;
            state_d = S_ACC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_ld = 1'b1;
          if (cnt_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= F32M_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc_clr)     acc_q <= F32M_ZERO;
      else if (acc_ld) acc_q <= sum;
      if (cnt_ld)      cnt_q <= n_ops;
      else if (acc_ld) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign out_data = acc_q;
  assign busy     = (state_q != S_IDLE);

endmodule
